// File: rtl/bsg_normalize_pkg.sv
// rtl/bsg_normalize_pkg.sv - shared widths, shift-amount width function and stage payload type
// Exponent field present only when BSG_NORMALIZE_EXP_EN is defined.
package bsg_normalize_pkg;

    localparam int width_lp     = 32;
    localparam int exp_width_lp = 8;

    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int shamt_width_lp = shamt_width(width_lp);

    typedef struct packed {
        logic [width_lp-1:0]       data;
        logic [shamt_width_lp-1:0] clz;
        logic                      zero;
`ifdef BSG_NORMALIZE_EXP_EN
        logic [exp_width_lp-1:0]   exp;
        logic                      uflow;
`endif
    } payload_s;

endpackage

// File: rtl/bsg_counting_leading_zeros.sv
// rtl/bsg_counting_leading_zeros.sv - combinational leading-zero count
// An all-zero input reports 0 (the count wraps); callers flag zero separately.
module bsg_counting_leading_zeros #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0]         a_i,
    output logic [$clog2(width_p)-1:0] num_zero_o
);

    localparam int lz_w_lp = $clog2(width_p);

    // Later (higher) bits overwrite earlier ones, leaving the highest set bit's count.
    always_comb begin
        num_zero_o = '0;
        for (int i = 0; i < width_p; i++) begin
            if (a_i[i]) begin
                num_zero_o = lz_w_lp'(width_p - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bsg_normalize_pipe_stage.sv
// rtl/bsg_normalize_pipe_stage.sv - one valid + payload pipeline register with advance logic
// Loads whenever empty or the downstream takes the current item.
module bsg_normalize_pipe_stage #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic               v_q, v_d;
    logic [width_p-1:0] data_q, data_d;

    assign ready_o = ~v_q | yumi_i;
    assign v_o     = v_q;
    assign data_o  = data_q;

    // Payload only changes on a real load so a drained stage keeps its last value.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (ready_o) begin
            v_d = v_i;
            if (v_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/bsg_normalize_pipe.sv
// rtl/bsg_normalize_pipe.sv - two-stage left normalizer with valid/ready in, valid/yumi out
// Optional exponent adjust and underflow saturation under BSG_NORMALIZE_EXP_EN.
module bsg_normalize_pipe
    import bsg_normalize_pkg::*;
#(
    parameter int width_p     = width_lp,
    parameter int exp_width_p = exp_width_lp
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [width_p-1:0]             data_i,
    output logic                           ready_o,
    output logic                           v_o,
    output logic [width_p-1:0]             data_o,
    output logic [shamt_width(width_p)-1:0] shamt_o,
    output logic                           zero_o,
    input  logic                           yumi_i
`ifdef BSG_NORMALIZE_EXP_EN
    ,
    input  logic [exp_width_p-1:0]         exp_i,
    output logic [exp_width_p-1:0]         exp_o,
    output logic                           uflow_o
`endif
);

    localparam int pl_w_lp = $bits(payload_s);

    // The payload type is sized from the package, so the parameters must agree with it.
    if (width_p != width_lp || exp_width_p != exp_width_lp) begin : g_param_check
        $error("bsg_normalize_pipe: parameters must match bsg_normalize_pkg widths");
    end

    payload_s                  in_pl, s1_pl, sh_pl, s2_pl;
    logic [shamt_width_lp-1:0] clz_raw;
    logic                      s1_v, s2_v, s2_ready;

    bsg_counting_leading_zeros #(.width_p(width_p)) clz (
        .a_i        (data_i),
        .num_zero_o (clz_raw)
    );

    always_comb begin
        in_pl      = '0;
        in_pl.data = data_i;
        in_pl.zero = ~|data_i;
        in_pl.clz  = in_pl.zero ? '0 : clz_raw;
`ifdef BSG_NORMALIZE_EXP_EN
        in_pl.exp  = exp_i;
`endif
    end

    bsg_normalize_pipe_stage #(.width_p(pl_w_lp)) s1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (in_pl),
        .ready_o (ready_o),
        .v_o     (s1_v),
        .data_o  (s1_pl),
        .yumi_i  (s2_ready)
    );

    // Shift and exponent adjust sit between the stages.
    always_comb begin
        sh_pl      = s1_pl;
        sh_pl.data = s1_pl.data << s1_pl.clz;
`ifdef BSG_NORMALIZE_EXP_EN
        sh_pl.uflow = 1'b0;
        if (s1_pl.zero) begin
            sh_pl.exp = '0;
        end else if (int'(s1_pl.clz) > int'(s1_pl.exp)) begin
            sh_pl.exp   = '0;
            sh_pl.uflow = 1'b1;
        end else begin
            sh_pl.exp = s1_pl.exp - exp_width_p'(s1_pl.clz);
        end
`endif
    end

    bsg_normalize_pipe_stage #(.width_p(pl_w_lp)) s2 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (s1_v),
        .data_i  (sh_pl),
        .ready_o (s2_ready),
        .v_o     (s2_v),
        .data_o  (s2_pl),
        .yumi_i  (yumi_i)
    );

    assign v_o     = s2_v;
    assign data_o  = s2_pl.data;
    assign shamt_o = s2_pl.clz;
    assign zero_o  = s2_pl.zero;
`ifdef BSG_NORMALIZE_EXP_EN
    assign exp_o   = s2_pl.exp;
    assign uflow_o = s2_pl.uflow;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!yumi_i || s2_v);
        end
    end

endmodule

// File: tb/tb_bsg_normalize_pipe.sv
// tb/tb_bsg_normalize_pipe.sv - directed vectors, streaming scoreboard, stall and reset sequences
// Exponent checks compiled in with BSG_NORMALIZE_EXP_EN.
module tb_bsg_normalize_pipe;

    logic        clk = 1'b0;
    logic        reset_i, v_i, ready_o, v_o, zero_o, yumi_i;
    logic [31:0] data_i, data_o;
    logic [4:0]  shamt_o;
`ifdef BSG_NORMALIZE_EXP_EN
    logic [7:0]  exp_i, exp_o;
    logic        uflow_o;
`endif

    always #5 clk = ~clk;

    bsg_normalize_pipe dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .shamt_o (shamt_o),
        .zero_o  (zero_o),
        .yumi_i  (yumi_i)
`ifdef BSG_NORMALIZE_EXP_EN
        ,
        .exp_i   (exp_i),
        .exp_o   (exp_o),
        .uflow_o (uflow_o)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        z;
        logic [7:0]  e;
        logic        u;
    } exp_t;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [4:0]  sh;
        logic        z;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_taken = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Independent model: locate the highest set bit from the top down.
    function automatic exp_t model(input logic [31:0] d, input logic [7:0] e);
        exp_t r;
        int   msb;
        r.d = d; r.s = '0; r.z = (d == 32'd0); r.e = '0; r.u = 1'b0;
        if (!r.z) begin
            msb = -1;
            for (int i = 31; i >= 0; i--) begin
                if (msb < 0 && d[i]) msb = i;
            end
            r.s = 5'(31 - msb);
            r.d = d << (31 - msb);
            if ((31 - msb) > int'(e)) r.u = 1'b1;
            else r.e = e - 8'(31 - msb);
        end
        return r;
    endfunction

    // Called at a negedge: drive inputs, score a take, record an accept, advance one cycle.
    task automatic cycle(input logic nv, input logic [31:0] nd, input logic [7:0] ne,
                         input logic ny, output logic rdy, output logic vo);
        exp_t e;
        v_i    = nv;
        data_i = nd;
`ifdef BSG_NORMALIZE_EXP_EN
        exp_i  = ne;
`endif
        yumi_i = ny & v_o;
        #1;
        rdy = ready_o;
        vo  = v_o;
        if (yumi_i) begin
            n_taken++;
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("stream_item", {26'd0, data_o, shamt_o, zero_o}, {26'd0, e.d, e.s, e.z});
`ifdef BSG_NORMALIZE_EXP_EN
                check("stream_exp", {exp_o, uflow_o}, {e.e, e.u});
`endif
            end
        end
        if (v_i && ready_o) sb.push_back(model(nd, ne));
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[8];
        logic        r, vo;
        logic [4:0]  rdy_seen;
        logic [31:0] stall_d[5];
        int          taken0;

        vecs[0] = '{32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 5'd0,  1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0};
        vecs[4] = '{32'h0000_0100, 32'h8000_0000, 5'd23, 1'b0};
        vecs[5] = '{32'h0001_2345, 32'h91A2_8000, 5'd15, 1'b0};
        vecs[6] = '{32'h4000_0000, 32'h8000_0000, 5'd1,  1'b0};
        vecs[7] = '{32'h0F00_00F0, 32'hF000_0F00, 5'd4,  1'b0};
        stall_d = '{32'h0000_00F0, 32'h0001_0000, 32'h0000_0007, 32'h1234_5678, 32'h0000_0003};

        reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
`ifdef BSG_NORMALIZE_EXP_EN
        exp_i = '0;
`endif
        repeat (3) @(negedge clk);
        check("reset_v_o", {63'd0, v_o}, 64'd0);
        check("reset_data_o", {32'd0, data_o}, 64'd0);
        check("reset_shamt_o", {59'd0, shamt_o}, 64'd0);
        check("reset_zero_o", {63'd0, zero_o}, 64'd0);
`ifdef BSG_NORMALIZE_EXP_EN
        check("reset_exp", {exp_o, uflow_o}, 64'd0);
`endif
        reset_i = 1'b0;
        @(negedge clk);

        // Single items: latency 2, hand-computed results.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i].din, 8'd200, 1'b0, r, vo);
            check("vec_ready", {63'd0, r}, 64'd1);
            cycle(1'b0, 32'd0, 8'd0, 1'b0, r, vo);
            check("vec_latency1_v_o", {63'd0, vo}, 64'd0);
            check("vec_v_o", {63'd0, v_o}, 64'd1);
            check("vec_data_o", {32'd0, data_o}, {32'd0, vecs[i].dout});
            check("vec_shamt_o", {59'd0, shamt_o}, {59'd0, vecs[i].sh});
            check("vec_zero_o", {63'd0, zero_o}, {63'd0, vecs[i].z});
            cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        end
        check("vec_sb_empty", 64'(sb.size()), 64'd0);

        // Back-to-back stream with yumi held high.
        taken0 = n_taken;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, $urandom >> $urandom_range(0, 31), 8'($urandom), 1'b1, r, vo);
            if (r !== 1'b1) check("stream_ready", {63'd0, r}, 64'd1);
            if (i >= 2 && vo !== 1'b1) check("stream_v_o", {63'd0, vo}, 64'd1);
        end
        check("stream_ready_last", {63'd0, ready_o}, 64'd1);
        repeat (3) cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        check("stream_count", 64'(n_taken - taken0), 64'd1000);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // Stall: consumer idle for 5 cycles while the producer keeps offering.
        taken0 = n_taken;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, stall_d[k], 8'd50, 1'b0, r, vo);
            rdy_seen[k] = r;
            if (k >= 2) begin
                check("stall_v_o", {63'd0, vo}, 64'd1);
                check("stall_data_o", {32'd0, data_o}, 64'hF000_0000);
                check("stall_shamt_o", {59'd0, shamt_o}, 64'd24);
            end
        end
        check("stall_ready_seq", {59'd0, rdy_seen}, 64'b00011);
        repeat (4) cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        check("stall_drain_count", 64'(n_taken - taken0), 64'd2);
        check("stall_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with two items in flight.
        cycle(1'b1, 32'h0000_0003, 8'd10, 1'b0, r, vo);
        cycle(1'b1, 32'h0000_0005, 8'd10, 1'b0, r, vo);
        v_i = 1'b0; yumi_i = 1'b0; reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        check("rst_flight_v_o", {63'd0, v_o}, 64'd0);
        check("rst_flight_data_o", {32'd0, data_o}, 64'd0);
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
            check("rst_no_stale", {63'd0, vo}, 64'd0);
        end
        taken0 = n_taken;
        cycle(1'b1, 32'h0000_0002, 8'd40, 1'b1, r, vo);
        repeat (3) cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        check("rst_recover_count", 64'(n_taken - taken0), 64'd1);

`ifdef BSG_NORMALIZE_EXP_EN
        cycle(1'b1, 32'h0000_0100, 8'd3, 1'b0, r, vo);
        cycle(1'b0, 32'd0, 8'd0, 1'b0, r, vo);
        check("exp_uflow_data", {32'd0, data_o}, 64'h8000_0000);
        check("exp_uflow", {exp_o, uflow_o}, {8'd0, 1'b1});
        cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        cycle(1'b1, 32'h0000_0100, 8'd100, 1'b0, r, vo);
        cycle(1'b0, 32'd0, 8'd0, 1'b0, r, vo);
        check("exp_adjust", {exp_o, uflow_o}, {8'd77, 1'b0});
        cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
        cycle(1'b1, 32'h0000_0000, 8'd9, 1'b0, r, vo);
        cycle(1'b0, 32'd0, 8'd0, 1'b0, r, vo);
        check("exp_zero", {exp_o, uflow_o}, {8'd0, 1'b0});
        cycle(1'b0, 32'd0, 8'd0, 1'b1, r, vo);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
